data_mem_unit: RTL
==================

Name: data_mem_unit

Overview:
Data-memory stage sitting directly downstream of the datapath's EX/MEM pipeline register. It consumes the registered ALU result as the address, the forwarded rs2 as store data, and the MEM-stage funct3/MemRW. It returns load data on Mem, which the datapath registers into its write-back mux.
Implements little-endian byte/half/word stores and sign/zero-extending loads, alignment and range checking, a saturating error counter and an optional MMIO cycle counter.

Parameters:
DATA_WIDTH, 32, data/address width; only 32 is supported.
DEPTH, 1024, number of 32-bit words in the RAM array.
ADDR_W, $clog2(DEPTH), word-index width; derived, never overridden.
MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; only used with DMEM_MMIO_EN.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemAcc  in  1  MEM-stage instruction is a load or store
MemRW  in  1  1 = store, 0 = load; qualified by MemAcc
Funct3  in  3  MEM-stage instruction bits [14:12]
Addr  in  DATA_WIDTH  byte address (Pipelined_ALU_Result)
WData  in  DATA_WIDTH  store data (Pipelined_Rs2_2)
Mem  out  DATA_WIDTH  load data, combinational from Addr/Funct3/array
Misaligned  out  1  combinational: current access is misaligned
OutOfRange  out  1  combinational: current access hits no RAM or MMIO location
ErrCnt  out  8  saturating count of faulting accesses

Behaviour:
- One clock domain. Async reset clears ErrCnt and the cycle counter. The RAM array is not reset.
- Combinational outputs under reset: Mem = 0 unless a valid load is presented; Misaligned = 0 and OutOfRange = 0 unless MemAcc = 1.
- Load latency: 0 cycles. Mem is valid in the same cycle as Addr, so the datapath can register it.
- Store: the write lands at the rising edge when MemAcc & MemRW & no fault.
- Read-during-write to the same word returns the old contents.
- Funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Bytes are selected by Addr[1:0], halfwords by Addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Funct3 for stores: 000 SB, 001 SH, 010 SW.
  - Per-byte write enables; untouched bytes are preserved.
- Word index = Addr[ADDR_W+1:2]. The RAM is hit only when Addr[31:ADDR_W+2] == 0.
- Misaligned = MemAcc & ((halfword & Addr[0]) | (word & Addr[1:0] != 0)).
- OutOfRange = MemAcc & address maps to neither RAM nor an enabled MMIO register.
- Illegal Funct3 (011, 110, 111) with MemAcc = 1 is treated as a fault and reported on OutOfRange.
- On any fault:
  - the store is suppressed;
  - Mem = 0;
  - ErrCnt increments at the clock edge and saturates at 8'hFF, with no wrap.
- MemAcc = 0: Mem = 0, no write, no count.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - 64-bit cycle counter, incremented every cycle after reset; wraps from all-ones to 0.
  - MMIO_BASE+0: LW returns counter[31:0].
  - MMIO_BASE+4: LW returns counter[63:32].
  - MMIO_BASE+8: LW returns {24'b0, ErrCnt}. An SW there clears ErrCnt. If a fault occurs in the same cycle, the clear wins.
  - Stores to +0/+4 are ignored and are not faults.
  - A non-word access to the MMIO window is Misaligned if its address is unaligned, otherwise OutOfRange.
- Undefined: no counter logic; the MMIO window is OutOfRange like any other unmapped address.

Decomposition:
- Shared package rv_mem_pkg:
  - funct3 encodings (F3_LB…F3_SW);
  - MMIO offsets;
  - ERRCNT_W = 8.
- One natural sub-module: load_align. It is combinational and handles byte/half extraction plus sign/zero extension, taking word, Addr[1:0] and Funct3.
- Store byte-enable generation stays inline.

Test Plan:
- SW 0x8765_4321 @0x10, then LB/LBU @0x13 -> Mem = 0xFFFF_FF87 / 0x0000_0087; LH @0x12 -> 0xFFFF_8765; LHU @0x10 -> 0x0000_4321.
- SB 0xAA @0x11 over word 0x8765_4321 -> LW @0x10 = 0x8765_AA21; SH 0xBEEF @0x12 -> LW = 0xBEEF_AA21.
- LW @0x06 and SH @0x21 -> Misaligned = 1, Mem = 0, memory unchanged, ErrCnt = 2; 300 faulting accesses -> ErrCnt holds 0xFF.
- SW @ DEPTH*4 (0x1000 with default) -> OutOfRange = 1, write dropped; Funct3 = 3'b111 -> OutOfRange = 1.
- Reset asserted mid-sequence with ErrCnt = 5 -> ErrCnt = 0 immediately, without waiting for a clock edge; the RAM word written before reset still reads back.
- DMEM_MMIO_EN: 10 cycles after reset release, LW @MMIO_BASE -> 10; SW @MMIO_BASE+8 -> ErrCnt = 0; LB @MMIO_BASE -> OutOfRange = 1.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the data-memory stage: load/store funct3 values,
// MMIO register offsets and the error-counter width.
package rv_mem_pkg;

  localparam int ERRCNT_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] MMIO_OFF_CNT_LO = 2'd0;
  localparam logic [1:0] MMIO_OFF_CNT_HI = 2'd1;
  localparam logic [1:0] MMIO_OFF_ERRCNT = 2'd2;

  // Only the unsigned load forms exist beyond the three store widths.
  function automatic logic f3_is_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = !is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_unit_load_align.sv
// load_align: extracts the addressed byte/halfword from a 32-bit word and
// applies sign or zero extension according to the load funct3.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension.
  always_comb begin
    byte_s = word_i[{byte_off_i, 3'b000} +: 8];
    half_s = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'h00_0000, byte_s};
      F3_LHU:  data_o = {16'h0000, half_s};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word RAM access with fault checking and a
// saturating error counter. Define DMEM_MMIO_EN to add the MMIO cycle counter.
module data_mem_unit
  import rv_mem_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemAcc,
  input  logic                  MemRW,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic [DATA_WIDTH-1:0] Mem,
  output logic                  Misaligned,
  output logic                  OutOfRange,
  output logic [ERRCNT_W-1:0]   ErrCnt
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
  logic [ADDR_W-1:0]     word_idx_s;
  logic                  ram_hit_s, mmio_win_s, mmio_reg_s;
  logic                  is_h_s, is_w_s, legal_s, mis_s, oor_s, fault_s;
  logic                  store_s, errclr_s;
  logic [3:0]            be_s;
  logic [DATA_WIDTH-1:0] wdata_s, mmio_rdata_s, src_word_s, aligned_s;

  assign word_idx_s = Addr[ADDR_W+1:2];
  assign ram_hit_s  = (Addr[DATA_WIDTH-1:ADDR_W+2] == {(DATA_WIDTH-ADDR_W-2){1'b0}});
  assign mmio_win_s = (Addr[DATA_WIDTH-1:4] == MMIO_BASE[DATA_WIDTH-1:4]);

  assign is_h_s  = (Funct3 == F3_LH) || (!MemRW && Funct3 == F3_LHU);
  assign is_w_s  = (Funct3 == F3_LW);
  assign legal_s = f3_is_legal(Funct3, MemRW);
  assign mis_s   = (is_h_s && Addr[0]) || (is_w_s && Addr[1:0] != 2'b00);
  // Inside the MMIO window only aligned words are mapped; an aligned narrow
  // access there is unmapped rather than misaligned.
  assign oor_s   = !legal_s || (!ram_hit_s && !mmio_reg_s)
                 || (mmio_reg_s && !is_w_s && !mis_s)
                 || (mmio_win_s && !mmio_reg_s);

  assign Misaligned = MemAcc && mis_s;
  assign OutOfRange = MemAcc && oor_s;
  assign fault_s    = Misaligned || OutOfRange;
  assign store_s    = MemAcc && MemRW && !fault_s;

`ifdef DMEM_MMIO_EN
  logic [63:0] cycle_q, cycle_d;

  assign mmio_reg_s = mmio_win_s && (Addr[3:2] != 2'b11);
  assign errclr_s   = store_s && mmio_reg_s && (Addr[3:2] == MMIO_OFF_ERRCNT);
  assign cycle_d    = cycle_q + 64'd1;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_q <= 64'd0;
    else        cycle_q <= cycle_d;
  end

  // MMIO register read mux.
  always_comb begin
    case (Addr[3:2])
      MMIO_OFF_CNT_LO: mmio_rdata_s = cycle_q[31:0];
      MMIO_OFF_CNT_HI: mmio_rdata_s = cycle_q[63:32];
      MMIO_OFF_ERRCNT: mmio_rdata_s = {{(DATA_WIDTH-ERRCNT_W){1'b0}}, errcnt_q};
      default:         mmio_rdata_s = {DATA_WIDTH{1'b0}};
    endcase
  end
`else
  assign mmio_reg_s   = 1'b0;
  assign errclr_s     = 1'b0;
  assign mmio_rdata_s = {DATA_WIDTH{1'b0}};
`endif

  // Store byte enables and lane replication.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = WData;
    if (store_s && ram_hit_s) begin
      case (Funct3)
        F3_SB: begin
          be_s    = 4'b0001 << Addr[1:0];
          wdata_s = {4{WData[7:0]}};
        end
        F3_SH: begin
          be_s    = Addr[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{WData[15:0]}};
        end
        F3_SW:   be_s = 4'b1111;
        default: be_s = 4'b0000;
      endcase
    end else begin
      be_s = 4'b0000;
    end
  end

  // RAM array, deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_s[b]) mem_q[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
    end
  end

  assign src_word_s = ram_hit_s ? mem_q[word_idx_s] : mmio_rdata_s;

  load_align u_load_align (
    .word_i     (src_word_s),
    .byte_off_i (Addr[1:0]),
    .funct3_i   (Funct3),
    .data_o     (aligned_s)
  );

  assign Mem = (MemAcc && !MemRW && !fault_s) ? aligned_s : {DATA_WIDTH{1'b0}};

  // Error counter next state; a software clear takes priority.
  always_comb begin
    errcnt_d = errcnt_q;
    if (errclr_s) begin
      errcnt_d = {ERRCNT_W{1'b0}};
    end else if (fault_s && errcnt_q != {ERRCNT_W{1'b1}}) begin
      errcnt_d = errcnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errcnt_q <= {ERRCNT_W{1'b0}};
    else        errcnt_q <= errcnt_d;
  end

  assign ErrCnt = errcnt_q;

endmodule
